// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// owner codes for the select line, and the round-robin pick helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWNER_IFETCH = 1'b0;
    localparam logic OWNER_LSU    = 1'b1;

    // Round-robin winner: a lone requester always wins; on contention the
    // requester that did not win last time gets the port.
    function automatic logic rr_pick(input logic req_0, input logic req_1,
                                     input logic last_gnt);
        if (req_0 && req_1) return ~last_gnt;
        if (req_0)          return OWNER_IFETCH;
        return OWNER_LSU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Plain 2:1 data mux used for the shared memory address and write-data paths.
module mem_port_arbiter_mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch
// (owner 0) and load/store (owner 1) with round-robin arbitration, runs the
// req/ready handshake and returns read data with a one-cycle done pulse.
// Optional macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts the
// transaction after TIMEOUT_CYC cycles and raises a sticky err flag.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// BUSY  | mem_req high, waiting for mem_ready (or watchdog expiry)
// DONE  | one-cycle done pulse to the owner, then back to IDLE
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic [DATA_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              we_0,
    input  logic              req_1,
    input  logic [DATA_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              we_1,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel,
    output logic              done_0,
    output logic              done_1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    logic              r_sel;
    logic              r_last_gnt;
    logic              r_mem_req;
    logic              r_done_0;
    logic              r_done_1;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic              w_pick;
    logic              w_we_sel;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    assign err = r_err;
`else
    // Without the watchdog the timeout length has no effect.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    assign w_pick   = rr_pick(req_0, req_1, r_last_gnt);
    assign w_we_sel = r_sel ? we_1 : we_0;

    assign mem_req = r_mem_req;
    assign mem_we  = w_we_sel & r_mem_req;
    assign sel     = r_sel;
    assign done_0  = r_done_0;
    assign done_1  = r_done_1;
    assign rdata   = r_rdata;
    assign busy    = r_busy;

    mem_port_arbiter_mux2 #(.W(DATA_W)) u_addr_mux (
        .i_a   (addr_0),
        .i_b   (addr_1),
        .i_sel (r_sel),
        .o_y   (mem_addr)
    );

    mem_port_arbiter_mux2 #(.W(DATA_W)) u_wdata_mux (
        .i_a   (wdata_0),
        .i_b   (wdata_1),
        .i_sel (r_sel),
        .o_y   (mem_wdata)
    );

    // Arbitration FSM with all outputs registered; done pulses default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= OWNER_IFETCH;
            r_last_gnt <= OWNER_LSU;
            r_mem_req  <= 1'b0;
            r_done_0   <= 1'b0;
            r_done_1   <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done_0 <= 1'b0;
            r_done_1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_0 || req_1) begin
                        r_sel      <= w_pick;
                        r_last_gnt <= w_pick;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        r_rdata   <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_done_0  <= (r_sel == OWNER_IFETCH);
                        r_done_1  <= (r_sel == OWNER_LSU);
                        r_state   <= ST_DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Abort: complete the handshake with zero data.
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_done_0  <= (r_sel == OWNER_IFETCH);
                        r_done_1  <= (r_sel == OWNER_LSU);
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for contention / reset / timeout corners, and a randomized run
// against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1, we_0, we_1, mem_ready;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1, mem_rdata;
    logic        mem_req, mem_we, sel, done_0, done_1, busy, err;
    logic [31:0] mem_addr, mem_wdata, rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.DATA_W(32), .TIMEOUT_CYC(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_0     (req_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .we_0      (we_0),
        .req_1     (req_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .we_1      (we_1),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .sel       (sel),
        .done_0    (done_0),
        .done_1    (done_1),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_mem_req(input int maxc, input string nm);
        bit ok = 0;
        for (int k = 0; k < maxc && !ok; k++) begin
            @(negedge clk); #1;
            ok = mem_req;
        end
        chk({nm, ".mem_req_seen"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int maxc, input string nm);
        bit ok = 0;
        for (int k = 0; k < maxc && !ok; k++) begin
            @(negedge clk); #1;
            ok = done_0 | done_1;
        end
        chk({nm, ".done_seen"}, {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic        req0; logic [31:0] a0; logic [31:0] w0; logic we0;
        logic        req1; logic [31:0] a1; logic [31:0] w1; logic we1;
        logic        rdy;  logic [31:0] rd;
        logic        e_req, e_sel, e_d0, e_d1, e_busy, e_we;
        logic [31:0] e_addr, e_wdata, e_rdata;
    } vec_t;

    vec_t vt[11];

    // random-phase model state
    int          own, t_done, waitn, n, nb;
    bit          m_last, m_sel, exp_w, got;
    logic [31:0] m_rdata;
    logic        e_req, e_d0, e_d1, e_we;
    logic [31:0] e_addr, e_wdata;

    initial begin
        //        req0 a0        w0  we0 req1 a1         w1            we1 rdy rd            req sel d0 d1 bsy we addr       wdata         rdata
        vt[0]  = '{1, 32'h40, 0, 0, 0, 0,        0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0,         0,            0};
        vt[1]  = '{1, 32'h40, 0, 0, 0, 0,        0,            0, 0, 0,            1, 0, 0, 0, 1, 0, 32'h40,    0,            0};
        vt[2]  = '{1, 32'h40, 0, 0, 0, 0,        0,            0, 0, 0,            1, 0, 0, 0, 1, 0, 32'h40,    0,            0};
        vt[3]  = '{1, 32'h40, 0, 0, 0, 0,        0,            0, 1, 32'hDEADBEEF, 1, 0, 0, 0, 1, 0, 32'h40,    0,            0};
        vt[4]  = '{0, 32'h40, 0, 0, 0, 0,        0,            0, 0, 0,            0, 0, 1, 0, 1, 0, 0,         0,            32'hDEADBEEF};
        vt[5]  = '{0, 0,      0, 0, 0, 0,        0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0,         0,            32'hDEADBEEF};
        vt[6]  = '{0, 0,      0, 0, 1, 32'h100, 32'h12345678, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0,         0,            32'hDEADBEEF};
        vt[7]  = '{0, 0,      0, 0, 1, 32'h100, 32'h12345678, 1, 1, 32'hCAFEF00D, 1, 1, 0, 0, 1, 1, 32'h100,   32'h12345678, 32'hDEADBEEF};
        vt[8]  = '{0, 0,      0, 0, 0, 32'h100, 32'h12345678, 1, 0, 0,            0, 1, 0, 1, 1, 0, 0,         0,            32'hCAFEF00D};
        vt[9]  = '{0, 0,      0, 0, 0, 0,        0,            0, 1, 32'hBAD0BAD0, 0, 1, 0, 0, 0, 0, 0,         0,            32'hCAFEF00D};
        vt[10] = '{0, 0,      0, 0, 0, 0,        0,            0, 0, 0,            0, 1, 0, 0, 0, 0, 0,         0,            32'hCAFEF00D};

        rst = 1'b1;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; mem_ready = 0;
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.mem_req", {31'd0, mem_req}, 0);
        chk("reset.sel",     {31'd0, sel},     0);
        chk("reset.done",    {30'd0, done_1, done_0}, 0);
        chk("reset.busy",    {31'd0, busy},    0);
        chk("reset.rdata",   rdata,            0);
        chk("reset.err",     {31'd0, err},     0);
        rst = 1'b0;

        // directed vector table: single read, single write, ignored idle ready
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req_0 = vt[i].req0; addr_0 = vt[i].a0; wdata_0 = vt[i].w0; we_0 = vt[i].we0;
            req_1 = vt[i].req1; addr_1 = vt[i].a1; wdata_1 = vt[i].w1; we_1 = vt[i].we1;
            mem_ready = vt[i].rdy; mem_rdata = vt[i].rd;
            #1;
            chk($sformatf("v%0d.mem_req", i), {31'd0, mem_req}, {31'd0, vt[i].e_req});
            chk($sformatf("v%0d.sel", i),     {31'd0, sel},     {31'd0, vt[i].e_sel});
            chk($sformatf("v%0d.done_0", i),  {31'd0, done_0},  {31'd0, vt[i].e_d0});
            chk($sformatf("v%0d.done_1", i),  {31'd0, done_1},  {31'd0, vt[i].e_d1});
            chk($sformatf("v%0d.busy", i),    {31'd0, busy},    {31'd0, vt[i].e_busy});
            chk($sformatf("v%0d.mem_we", i),  {31'd0, mem_we},  {31'd0, vt[i].e_we});
            chk($sformatf("v%0d.rdata", i),   rdata,            vt[i].e_rdata);
            chk($sformatf("v%0d.err", i),     {31'd0, err},     0);
            if (vt[i].e_req) begin
                chk($sformatf("v%0d.mem_addr", i),  mem_addr,  vt[i].e_addr);
                chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vt[i].e_wdata);
            end
        end

        // contention: both held for four transactions, immediate ready
        @(negedge clk);
        req_0 = 1; addr_0 = 32'h1000; we_0 = 0; wdata_0 = 0;
        req_1 = 1; addr_1 = 32'h2000; we_1 = 0; wdata_1 = 0;
        mem_ready = 1; mem_rdata = 32'hA5A50000;
        exp_w = 1'b0; n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk); #1;
            chk("contention.exclusive", {31'd0, done_0 & done_1}, 0);
            if (mem_req) begin
                chk("contention.sel", {31'd0, sel}, {31'd0, exp_w});
                chk("contention.mem_addr", mem_addr, exp_w ? addr_1 : addr_0);
            end
            if (done_0 || done_1) begin
                chk("contention.winner", {31'd0, done_1}, {31'd0, exp_w});
                chk("contention.rdata", rdata, 32'hA5A50000 + n);
                n++;
                if (done_1) addr_1 = addr_1 + 4; else addr_0 = addr_0 + 4;
                mem_rdata = 32'hA5A50000 + n;
                exp_w = ~exp_w;
            end
        end
        chk("contention.count", n, 4);
        req_0 = 0; req_1 = 0; mem_ready = 0;
        @(negedge clk);

        // request dropped during BUSY still completes
        req_0 = 1; addr_0 = 32'h500;
        wait_mem_req(10, "drop");
        @(negedge clk); req_0 = 0;
        @(negedge clk); mem_ready = 1; mem_rdata = 32'h55AA55AA;
        @(negedge clk); mem_ready = 0; #1;
        chk("drop.done_0", {31'd0, done_0}, 1);
        chk("drop.done_1", {31'd0, done_1}, 0);
        chk("drop.rdata",  rdata, 32'h55AA55AA);
        @(negedge clk); #1;
        chk("drop.done_0_cleared", {31'd0, done_0}, 0);
        chk("drop.busy_cleared",   {31'd0, busy},   0);

`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog: mem_ready stuck low
        req_0 = 1; addr_0 = 32'h600; mem_ready = 0;
        nb = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            if (mem_req) nb++;
            if (done_0) begin
                got = 1;
                chk("timeout.rdata", rdata, 0);
                chk("timeout.err",   {31'd0, err}, 1);
                req_0 = 0;
            end
        end
        chk("timeout.done_seen",   {31'd0, got}, 1);
        chk("timeout.busy_cycles", nb, 15);
        repeat (3) @(negedge clk);
        #1 chk("timeout.err_sticky", {31'd0, err}, 1);
        req_1 = 1; addr_1 = 32'h610; mem_ready = 1; mem_rdata = 32'h0F0F0F0F;
        wait_done(10, "timeout.next");
        req_1 = 0; mem_ready = 0;
        chk("timeout.next_rdata", rdata, 32'h0F0F0F0F);
        chk("timeout.err_after_txn", {31'd0, err}, 1);
        @(negedge clk); rst = 1;
        #1 chk("timeout.err_cleared", {31'd0, err}, 0);
        @(negedge clk); rst = 0;
`else
        // without the watchdog BUSY waits indefinitely
        req_0 = 1; addr_0 = 32'h600; mem_ready = 0;
        wait_mem_req(10, "nowd");
        repeat (40) @(negedge clk);
        #1;
        chk("nowd.mem_req_held", {31'd0, mem_req}, 1);
        chk("nowd.no_done",      {31'd0, done_0},  0);
        chk("nowd.err",          {31'd0, err},     0);
        mem_ready = 1; mem_rdata = 32'h0F0F0F0F;
        @(negedge clk); mem_ready = 0; req_0 = 0; #1;
        chk("nowd.done_0", {31'd0, done_0}, 1);
        chk("nowd.rdata",  rdata, 32'h0F0F0F0F);
        @(negedge clk);
`endif

        // async reset in the middle of a load/store transaction
        req_1 = 1; addr_1 = 32'h300; mem_ready = 0;
        wait_mem_req(10, "rst");
        chk("rst.sel_before", {31'd0, sel}, 1);
        #2 rst = 1;
        #1;
        chk("rst.mem_req", {31'd0, mem_req}, 0);
        chk("rst.sel",     {31'd0, sel},     0);
        chk("rst.busy",    {31'd0, busy},    0);
        @(negedge clk);
        rst = 0; req_0 = 1; addr_0 = 32'h700; req_1 = 1; addr_1 = 32'h704;
        wait_mem_req(10, "rst.regrant");
        chk("rst.regrant_sel",  {31'd0, sel}, 0);
        chk("rst.regrant_addr", mem_addr, 32'h700);
        mem_ready = 1; mem_rdata = 32'h77777777;
        @(negedge clk); mem_ready = 0; req_0 = 0; req_1 = 0; #1;
        chk("rst.regrant_done_0", {31'd0, done_0}, 1);
        chk("rst.regrant_done_1", {31'd0, done_1}, 0);

        // randomized run against a transaction-timeline model
        @(negedge clk); rst = 1;
        req_0 = 0; req_1 = 0; mem_ready = 0;
        @(negedge clk); rst = 0;
        own = -1; t_done = -1; waitn = 0;
        m_last = 1'b1; m_sel = 1'b0; m_rdata = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            e_req = (own >= 0) && (t_done < 0);
            e_d0  = (own == 0) && (c == t_done);
            e_d1  = (own == 1) && (c == t_done);
            if (e_d0) begin
                if ($urandom_range(1) == 1) begin
                    addr_0 = $urandom; wdata_0 = $urandom; we_0 = 1'($urandom_range(1));
                end else req_0 = 0;
            end else if (!req_0 && $urandom_range(2) == 0) begin
                req_0 = 1; addr_0 = $urandom; wdata_0 = $urandom; we_0 = 1'($urandom_range(1));
            end
            if (e_d1) begin
                if ($urandom_range(1) == 1) begin
                    addr_1 = $urandom; wdata_1 = $urandom; we_1 = 1'($urandom_range(1));
                end else req_1 = 0;
            end else if (!req_1 && $urandom_range(2) == 0) begin
                req_1 = 1; addr_1 = $urandom; wdata_1 = $urandom; we_1 = 1'($urandom_range(1));
            end
            waitn = e_req ? waitn + 1 : 0;
            mem_ready = ($urandom_range(2) == 0) || (waitn >= 6);
            mem_rdata = $urandom;
            e_addr  = m_sel ? addr_1 : addr_0;
            e_wdata = m_sel ? wdata_1 : wdata_0;
            e_we    = e_req & (m_sel ? we_1 : we_0);
            #1;
            chk("rand.mem_req", {31'd0, mem_req}, {31'd0, e_req});
            chk("rand.done",    {30'd0, done_1, done_0}, {30'd0, e_d1, e_d0});
            chk("rand.busy",    {31'd0, busy},   {31'd0, e_req | e_d0 | e_d1});
            chk("rand.sel",     {31'd0, sel},    {31'd0, m_sel});
            chk("rand.mem_we",  {31'd0, mem_we}, {31'd0, e_we});
            chk("rand.rdata",   rdata, m_rdata);
            chk("rand.err",     {31'd0, err}, 0);
            if (e_req) begin
                chk("rand.mem_addr",  mem_addr,  e_addr);
                chk("rand.mem_wdata", mem_wdata, e_wdata);
            end
            if (e_req && mem_ready) begin
                t_done  = c + 1;
                m_rdata = mem_rdata;
            end else if (e_d0 || e_d1) begin
                own = -1; t_done = -1;
            end else if (own < 0 && (req_0 || req_1)) begin
                if (req_0 && req_1) own = m_last ? 0 : 1;
                else                own = req_1 ? 1 : 0;
                m_last = (own == 1);
                m_sel  = (own == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port of the 4-stage pipeline between instruction fetch (requester 0) and load/store (requester 1).
- Arbitrates round-robin and owns the select line of the address/write-data 2:1 muxes.
- Sequences the request/ready handshake with memory.
- Returns read data and a one-cycle done pulse to the granted requester.

Parameters:
- DATA_W, 32, width of address, write data and read data.
- TIMEOUT_CYC, 15, max BUSY cycles before abort (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_0  in  1  fetch request; held with payload until done_0.
- addr_0  in  DATA_W  fetch address.
- wdata_0  in  DATA_W  fetch write data (normally unused).
- we_0  in  1  fetch write enable.
- req_1, addr_1, wdata_1, we_1  in  1/DATA_W/DATA_W/1  load/store request, same rules.
- mem_req  out  1  memory transaction valid.
- mem_addr  out  DATA_W  muxed address.
- mem_wdata  out  DATA_W  muxed write data.
- mem_we  out  1  muxed write enable, gated by mem_req.
- mem_ready  in  1  memory completes the transaction this cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- sel  out  1  current owner (0 = fetch, 1 = load/store); drives the muxes.
- done_0, done_1  out  1  one-cycle completion pulse per requester.
- rdata  out  DATA_W  registered read data, valid with done_x.
- busy  out  1  high in BUSY and DONE.
- err  out  1  timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (async, any state): state=IDLE, sel=0, last_gnt=1, mem_req=0, done_0=done_1=0, rdata=0, busy=0, err=0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - only req_0 -> grant 0; only req_1 -> grant 1.
  - both -> grant !last_gnt, so fetch wins the first contention after reset.
  - grant registers sel and last_gnt, then moves to BUSY.
  - no req -> stay in IDLE.
- BUSY:
  - mem_req=1; mem_addr/mem_wdata/mem_we follow the selected requester through the muxes.
  - mem_ready=1 -> rdata<=mem_rdata, go to DONE.
  - otherwise stay; the wait is unbounded without the feature.
- DONE:
  - lasts exactly one cycle; done_sel=1, mem_req=0, then IDLE.
  - the requester must drop or replace req at the edge ending DONE.
  - a req still high in the following IDLE is a new request.
- Latency: req seen in IDLE cycle N; mem_req high from N+1; mem_ready in cycle M; done in M+1; next grant earliest in M+2. Minimum 3 cycles per transaction.
- mem_ready outside BUSY is ignored.
- req deassertion during BUSY is ignored; the transaction completes and done still pulses.
- sel is held constant from grant through DONE.
- mem_we = we_sel & mem_req; it is 0 outside BUSY.
- done_0 and done_1 are never high together.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - a counter clears on entry to BUSY and increments each BUSY cycle.
  - when the count reaches TIMEOUT_CYC with no mem_ready, go to DONE with rdata=0 and set err=1.
  - err is sticky until rst.
- Not defined: no counter, err tied 0, BUSY waits indefinitely.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), OWNER_IFETCH=1'b0, OWNER_LSU=1'b1.
- Sub-modules: instantiate the existing 32-bit 2:1 mux module twice (address, write data); the FSM and arbitration stay in this module.

Test Plan:
- Reset then req_0 only, addr_0=0x00000040, mem_ready two cycles after mem_req, mem_rdata=0xDEADBEEF -> sel=0, mem_addr=0x40, done_0 pulse one cycle later, rdata=0xDEADBEEF.
- req_0 and req_1 held together for 4 transactions, mem_ready immediate -> grants alternate 0,1,0,1; done pulses alternate; never both.
- req_1 write, addr_1=0x100, wdata_1=0x12345678, we_1=1 -> mem_we=1 only during BUSY, mem_wdata=0x12345678, done_1 pulse.
- rst asserted mid-BUSY (mem_ready not yet high) -> same-cycle mem_req=0, sel=0, busy=0; next contention grants 0.
- mem_ready pulsed while IDLE, then req_0 dropped during BUSY -> idle pulse ignored; transaction still completes with done_0.
- With MEM_ARB_TIMEOUT_EN and mem_ready stuck low -> DONE after 15 BUSY cycles, rdata=0, err=1 and stays 1 until rst.
